sa_tag_directory: RTL and testbench
===================================

Name: sa_tag_directory

Overview:
- Parametrised N-way set-associative tag directory: the next generation of the fixed 8-set/8-way tag/valid lookup block.
- Adds a request/response handshake and tree pseudo-LRU replacement. Also adds hardware victim selection, per-line invalidate and a multi-cycle flush-all state machine.
- Sits between the core-side cache controller and the data array. The controller issues lookups and fills, then uses resp_way / resp_victim_way to address the data RAM.

Parameters:
- WAYS, 8, associativity; power of 2, range 2..16.
- SETS, 8, number of sets; power of 2, range 2..256.
- TAG_W, 24, tag width in bits.
- IDX_W, $clog2(SETS), index width (derived; do not override).
- WAY_W, $clog2(WAYS), way-number width (derived).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  directory can accept a request; 0 during flush.
- req_op  in  2  0=LOOKUP, 1=FILL, 2=INVAL, 3=FLUSH_ALL.
- req_tag  in  TAG_W  request tag.
- req_index  in  IDX_W  request set index.
- resp_valid  out  1  one-cycle response pulse.
- resp_hit  out  1  tag was valid and matched in the set at acceptance.
- resp_way  out  WAY_W  hit way; for FILL, the way written.
- resp_victim_way  out  WAY_W  way the next fill to this set would replace (LOOKUP miss only, else 0).
- busy  out  1  flush in progress.

Behaviour:
- Reset (reset=0, async): all valid bits=0, all PLRU bits=0, FSM=IDLE, flush counter=0. Outputs: req_ready=1, resp_valid=0, resp_hit=0, resp_way=0, resp_victim_way=0, busy=0. Tag storage is not reset.
- Accept means req_valid & req_ready at a rising edge. The set is read combinationally at acceptance. State update and registered response occur on the same edge, so latency is 1 cycle. Back-to-back requests are allowed every cycle; a request in cycle N+1 sees all updates from cycle N, including to the same set.
- Hit = OR over ways of (valid[w] & tag[w]==req_tag). If multiple ways match, the lowest-numbered way is reported; this is an error case the bench flags, the RTL does not prevent it.
- LOOKUP: on hit, touch the PLRU for resp_way. On miss, no state change; resp_victim_way = victim().
- victim(): the lowest-numbered invalid way if any, else the way pointed to by the PLRU tree.
- FILL, tag already present: no tag write, PLRU touch, resp_hit=1, resp_way = matching way.
- FILL, tag absent: write tag to victim(), set its valid bit, touch PLRU, resp_hit=0, resp_way = victim.
- INVAL: on hit, clear that way's valid bit; PLRU is unchanged. resp_hit and resp_way report the match; a miss gives resp_hit=0 and no state change.
- PLRU encoding: WAYS-1 bits per set, binary tree with node 1 as root. Node bit 0 means the victim lies in the lower half, 1 the upper half. Touching a way sets every node on its path to point away from it.
- FLUSH_ALL FSM, IDLE -> FLUSH on accept:
  - FLUSH: req_ready=0, busy=1.
  - Each cycle, clear valid and PLRU of set cnt, then cnt++.
  - When cnt==SETS-1 is cleared, go to IDLE and pulse resp_valid with resp_hit=0.
  - Flush therefore takes SETS cycles, with resp_valid on the edge that clears the last set.
  - req_valid is ignored while busy.
- Reset during FLUSH: immediate IDLE, everything cleared; no resp_valid pulse.
- resp_valid is 0 in every cycle without an accept or flush completion. Other resp_* fields hold their last values.

Decomposition:
- Package sa_dir_pkg: op enum (OP_LOOKUP/OP_FILL/OP_INVAL/OP_FLUSH), FSM state enum (ST_IDLE/ST_FLUSH), and pure functions plru_victim(bits) and plru_touch(bits, way) parametrised by WAYS.
- One sub-module, plru_tree: combinational victim and next-bits logic for a single set, instantiated once on the selected set.
- Tag/valid/PLRU arrays live in the top as flop arrays.

Test Plan (WAYS=4, SETS=8, TAG_W=24 unless noted):
- Cold fills: after reset, FILL set 3 with tags 0xA0,0xA1,0xA2,0xA3 on consecutive cycles. Required: resp_way 0,1,2,3 and resp_hit=0 each. A following LOOKUP of 0xA2 at set 3 gives resp_hit=1, resp_way=2 one cycle after accept.
- PLRU victim: after the fills, fill-order touches leave PLRU pointing at way 0. LOOKUP miss 0xB0 gives resp_victim_way=0. Then LOOKUP hit 0xA0 (way 0); then FILL 0xB0 gives resp_way=2, and LOOKUP 0xA2 misses.
- Duplicate fill: FILL of an existing tag gives resp_hit=1 at the same way, and the valid/tag contents of the other ways are unchanged.
- Invalidate: INVAL 0xA1 at set 3 gives resp_hit=1, resp_way=1. A later FILL 0xC0 gives resp_way=1 (invalid way preferred over PLRU).
- Flush: FLUSH_ALL gives req_ready=0 and busy=1 for exactly 8 cycles, then a single resp_valid pulse. A later LOOKUP of any prior tag gives resp_hit=0.
- Reset mid-flush: assert reset at flush cycle 4. Outputs go to reset values asynchronously, with req_ready=1 on release and no resp_valid pulse. Repeat the cold-fill test with WAYS=8, SETS=16.

Source files
------------

// File: rtl/sa_dir_pkg.sv
// Shared types and pseudo-LRU tree helpers for the set-associative tag directory.
package sa_dir_pkg;

  localparam int unsigned MAX_WAY_W = 4;
  localparam int unsigned MAX_NODES = 15;

  typedef enum logic [1:0] {
    OP_LOOKUP = 2'd0,
    OP_FILL   = 2'd1,
    OP_INVAL  = 2'd2,
    OP_FLUSH  = 2'd3
  } op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  // Node n (1 = root) lives at bits[n-1]; a 0 sends the walk to the lower child.
  function automatic logic [MAX_WAY_W-1:0] plru_victim(input logic [MAX_NODES-1:0] bits,
                                                       input int unsigned ways);
    int unsigned node;
    node = 1;
    for (int unsigned l = 0; l < MAX_WAY_W; l++) begin
      if ((32'd1 << l) < ways) begin
        node = 2 * node + 32'(bits[4'(node - 1)]);
      end
    end
    return MAX_WAY_W'(node - ways);
  endfunction

  // Every node on the path to 'way' is set to point at the other half.
  function automatic logic [MAX_NODES-1:0] plru_touch(input logic [MAX_NODES-1:0] bits,
                                                      input logic [MAX_WAY_W-1:0] way,
                                                      input int unsigned ways);
    logic [MAX_NODES-1:0] nb;
    int unsigned          node;
    int unsigned          lvls;
    logic                 dir;
    nb   = bits;
    node = 1;
    lvls = 0;
    for (int unsigned i = 0; i <= MAX_WAY_W; i++) begin
      if ((32'd1 << i) < ways) lvls++;
    end
    for (int unsigned l = 0; l < MAX_WAY_W; l++) begin
      if (l < lvls) begin
        dir                 = way[2'(lvls - 1 - l)];
        nb[4'(node - 1)]    = ~dir;
        node                = 2 * node + 32'(dir);
      end
    end
    return nb;
  endfunction

endpackage

// File: rtl/sa_tag_directory_if.sv
// Request/response bus between the cache controller and the tag directory.
interface sa_dir_if
  import sa_dir_pkg::*;
#(
  parameter int unsigned WAYS  = 8,
  parameter int unsigned SETS  = 8,
  parameter int unsigned TAG_W = 24
) ();
  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned WAY_W = $clog2(WAYS);

  logic             req_valid;
  logic             req_ready;
  op_e              req_op;
  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] req_index;
  logic             resp_valid;
  logic             resp_hit;
  logic [WAY_W-1:0] resp_way;
  logic [WAY_W-1:0] resp_victim_way;
  logic             busy;

  modport master (
    output req_valid, req_op, req_tag, req_index,
    input  req_ready, resp_valid, resp_hit, resp_way, resp_victim_way, busy
  );

  modport slave (
    input  req_valid, req_op, req_tag, req_index,
    output req_ready, resp_valid, resp_hit, resp_way, resp_victim_way, busy
  );
endinterface

// File: rtl/sa_tag_directory_plru_tree.sv
// Combinational tree pseudo-LRU for one set: victim pointer and post-touch bits.
module plru_tree
  import sa_dir_pkg::*;
#(
  parameter int unsigned WAYS = 8
) (
  input  logic [WAYS-2:0]         bits_i,
  input  logic [$clog2(WAYS)-1:0] touch_way_i,
  output logic [$clog2(WAYS)-1:0] victim_c_o,
  output logic [WAYS-2:0]         next_bits_c_o
);
  localparam int unsigned WAY_W = $clog2(WAYS);
  localparam int unsigned NODES = WAYS - 1;

  logic [MAX_NODES-1:0] bits_ext;

  assign bits_ext      = MAX_NODES'(bits_i);
  assign victim_c_o    = WAY_W'(plru_victim(bits_ext, WAYS));
  assign next_bits_c_o = NODES'(plru_touch(bits_ext, MAX_WAY_W'(touch_way_i), WAYS));
endmodule

// File: rtl/sa_tag_directory.sv
// N-way set-associative tag directory with tree PLRU, victim select, invalidate and flush-all.
module sa_tag_directory
  import sa_dir_pkg::*;
#(
  parameter int unsigned WAYS  = 8,
  parameter int unsigned SETS  = 8,
  parameter int unsigned TAG_W = 24
) (
  input logic     clk,
  input logic     reset,
  sa_dir_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned WAY_W = $clog2(WAYS);
  localparam int unsigned NODES = WAYS - 1;

  logic [TAG_W-1:0] tag_q   [SETS][WAYS];
  logic [WAYS-1:0]  valid_q [SETS];
  logic [NODES-1:0] plru_q  [SETS];

  state_e           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             resp_valid_q, resp_valid_d;
  logic             resp_hit_q, resp_hit_d;
  logic [WAY_W-1:0] resp_way_q, resp_way_d;
  logic [WAY_W-1:0] resp_vic_q, resp_vic_d;

  logic [IDX_W-1:0] idx;
  logic [WAYS-1:0]  set_valid;
  logic [NODES-1:0] set_plru;
  logic [WAYS-1:0]  hit_vec;
  logic             hit;
  logic [WAY_W-1:0] hit_way;
  logic             has_inv;
  logic [WAY_W-1:0] inv_way;
  logic [WAY_W-1:0] plru_vic;
  logic [WAY_W-1:0] victim;
  logic [WAY_W-1:0] touch_way;
  logic [NODES-1:0] plru_next;
  logic             accept;

  logic             tag_we;
  logic             valid_we;
  logic [WAYS-1:0]  valid_wdata;
  logic             plru_we;
  logic             flush_clr;

  assign idx       = bus.req_index;
  assign set_valid = valid_q[idx];
  assign set_plru  = plru_q[idx];

  // Tag compare across the selected set; the lowest matching way wins.
  always_comb begin
    hit_vec = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      hit_vec[w] = set_valid[w] && (tag_q[idx][w] == bus.req_tag);
    end
    hit_way = '0;
    inv_way = '0;
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (hit_vec[w])    hit_way = WAY_W'(w);
      if (!set_valid[w]) inv_way = WAY_W'(w);
    end
  end

  assign hit       = |hit_vec;
  assign has_inv   = ~&set_valid;
  assign victim    = has_inv ? inv_way : plru_vic;
  assign touch_way = hit ? hit_way : victim;
  assign accept    = bus.req_valid && ready_q;

  plru_tree #(.WAYS(WAYS)) u_plru (
    .bits_i       (set_plru),
    .touch_way_i  (touch_way),
    .victim_c_o   (plru_vic),
    .next_bits_c_o(plru_next)
  );

  // Next-state, response and array write-enable decode.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ready_d      = ready_q;
    busy_d       = busy_q;
    resp_valid_d = 1'b0;
    resp_hit_d   = resp_hit_q;
    resp_way_d   = resp_way_q;
    resp_vic_d   = resp_vic_q;
    tag_we       = 1'b0;
    valid_we     = 1'b0;
    valid_wdata  = set_valid;
    plru_we      = 1'b0;
    flush_clr    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (bus.req_op)
            OP_LOOKUP: begin
              resp_valid_d = 1'b1;
              resp_hit_d   = hit;
              resp_way_d   = hit ? hit_way : '0;
              resp_vic_d   = hit ? '0 : victim;
              plru_we      = hit;
            end
            OP_FILL: begin
              resp_valid_d = 1'b1;
              resp_hit_d   = hit;
              resp_way_d   = hit ? hit_way : victim;
              resp_vic_d   = '0;
              plru_we      = 1'b1;
              if (!hit) begin
                tag_we      = 1'b1;
                valid_we    = 1'b1;
                valid_wdata = set_valid | (WAYS'(1) << victim);
              end
            end
            OP_INVAL: begin
              resp_valid_d = 1'b1;
              resp_hit_d   = hit;
              resp_way_d   = hit ? hit_way : '0;
              resp_vic_d   = '0;
              if (hit) begin
                valid_we    = 1'b1;
                valid_wdata = set_valid & ~(WAYS'(1) << hit_way);
              end
            end
            OP_FLUSH: begin
              state_d = ST_FLUSH;
              ready_d = 1'b0;
              busy_d  = 1'b1;
              cnt_d   = '0;
            end
          endcase
        end
      end
      ST_FLUSH: begin
        flush_clr = 1'b1;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == IDX_W'(SETS - 1)) begin
          state_d      = ST_IDLE;
          ready_d      = 1'b1;
          busy_d       = 1'b0;
          resp_valid_d = 1'b1;
          resp_hit_d   = 1'b0;
          resp_vic_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      ready_q      <= 1'b1;
      busy_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_way_q   <= '0;
      resp_vic_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ready_q      <= ready_d;
      busy_q       <= busy_d;
      resp_valid_q <= resp_valid_d;
      resp_hit_q   <= resp_hit_d;
      resp_way_q   <= resp_way_d;
      resp_vic_q   <= resp_vic_d;
    end
  end

  // Valid and PLRU state; flush clears one set per cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else if (flush_clr) begin
      valid_q[cnt_q] <= '0;
      plru_q[cnt_q]  <= '0;
    end else begin
      if (valid_we) valid_q[idx] <= valid_wdata;
      if (plru_we)  plru_q[idx]  <= plru_next;
    end
  end

  // Tag storage carries no reset; entries are qualified by valid bits.
  always_ff @(posedge clk) begin
    if (tag_we) tag_q[idx][victim] <= bus.req_tag;
  end

  assign bus.req_ready       = ready_q;
  assign bus.busy            = busy_q;
  assign bus.resp_valid      = resp_valid_q;
  assign bus.resp_hit        = resp_hit_q;
  assign bus.resp_way        = resp_way_q;
  assign bus.resp_victim_way = resp_vic_q;
endmodule

// File: tb/tb_sa_tag_directory.sv
// Directed and randomized checks of sa_tag_directory against a set/way/tree reference model.
module tb_sa_tag_directory;
  import sa_dir_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sa_dir_if #(.WAYS(4), .SETS(8),  .TAG_W(24)) bus_a ();
  sa_dir_if #(.WAYS(8), .SETS(16), .TAG_W(24)) bus_b ();

  sa_tag_directory #(.WAYS(4), .SETS(8), .TAG_W(24)) dut_a (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_a)
  );

  sa_tag_directory #(.WAYS(8), .SETS(16), .TAG_W(24)) dut_b (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_b)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model for the 4-way, 8-set instance; tree node n in m_node[s][n].
  logic [23:0] m_tag  [8][4];
  bit          m_val  [8][4];
  bit          m_node [8][4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic m_clear();
    for (int s = 0; s < 8; s++)
      for (int w = 0; w < 4; w++) begin
        m_val[s][w]  = 1'b0;
        m_node[s][w] = 1'b0;
      end
  endtask

  function automatic int m_victim(input int s);
    int lo, span, n;
    for (int w = 0; w < 4; w++) if (!m_val[s][w]) return w;
    lo = 0; span = 4; n = 1;
    while (span > 1) begin
      span = span / 2;
      if (m_node[s][n]) begin lo = lo + span; n = 2 * n + 1; end
      else n = 2 * n;
    end
    return lo;
  endfunction

  task automatic m_touch(input int s, input int w);
    int lo, span, n;
    lo = 0; span = 4; n = 1;
    while (span > 1) begin
      span = span / 2;
      if (w >= lo + span) begin m_node[s][n] = 1'b0; lo = lo + span; n = 2 * n + 1; end
      else begin m_node[s][n] = 1'b1; n = 2 * n; end
    end
  endtask

  // One accepted request on instance A, checked against the model; returns what was observed.
  task automatic req_a(input op_e op, input logic [23:0] tag, input int idx,
                       output logic hit, output logic [1:0] way, output logic [1:0] vic);
    int  mh, nh, ev, e_way, e_vic;
    bit  e_hit;
    mh = -1; nh = 0;
    for (int w = 0; w < 4; w++)
      if (m_val[idx][w] && m_tag[idx][w] == tag) begin
        nh++;
        if (mh < 0) mh = w;
      end
    if (nh > 1) $error("FAIL multi_hit observed=%0d expected=1", nh);
    e_hit = (mh >= 0);
    ev    = m_victim(idx);
    e_vic = 0;
    e_way = 0;
    case (op)
      OP_LOOKUP: begin
        e_way = e_hit ? mh : 0;
        e_vic = e_hit ? 0 : ev;
        if (e_hit) m_touch(idx, mh);
      end
      OP_FILL: begin
        if (e_hit) begin
          e_way = mh;
          m_touch(idx, mh);
        end else begin
          e_way = ev;
          m_tag[idx][ev] = tag;
          m_val[idx][ev] = 1'b1;
          m_touch(idx, ev);
        end
      end
      default: begin
        e_way = e_hit ? mh : 0;
        if (e_hit) m_val[idx][mh] = 1'b0;
      end
    endcase
    chk("a_ready", 32'(bus_a.req_ready), 32'd1);
    bus_a.req_valid = 1'b1;
    bus_a.req_op    = op;
    bus_a.req_tag   = tag;
    bus_a.req_index = 3'(idx);
    @(posedge clk); #1;
    bus_a.req_valid = 1'b0;
    chk("a_resp_valid", 32'(bus_a.resp_valid), 32'd1);
    chk("a_resp_hit", 32'(bus_a.resp_hit), 32'(e_hit));
    chk("a_resp_way", 32'(bus_a.resp_way), 32'(e_way));
    chk("a_resp_victim", 32'(bus_a.resp_victim_way), 32'(e_vic));
    hit = bus_a.resp_hit;
    way = bus_a.resp_way;
    vic = bus_a.resp_victim_way;
  endtask

  initial begin
    logic       h;
    logic [1:0] w, v;
    int         n, pulses;

    reset = 1'b0;
    bus_a.req_valid = 1'b0; bus_a.req_op = OP_LOOKUP; bus_a.req_tag = '0; bus_a.req_index = '0;
    bus_b.req_valid = 1'b0; bus_b.req_op = OP_LOOKUP; bus_b.req_tag = '0; bus_b.req_index = '0;
    m_clear();
    #12;
    chk("rst_ready", 32'(bus_a.req_ready), 32'd1);
    chk("rst_busy", 32'(bus_a.busy), 32'd0);
    chk("rst_resp_valid", 32'(bus_a.resp_valid), 32'd0);
    chk("rst_resp_hit", 32'(bus_a.resp_hit), 32'd0);
    chk("rst_resp_way", 32'(bus_a.resp_way), 32'd0);
    chk("rst_victim", 32'(bus_a.resp_victim_way), 32'd0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    // Cold fills into set 3 on consecutive cycles.
    for (int i = 0; i < 4; i++) begin
      req_a(OP_FILL, 24'hA0 + 24'(i), 3, h, w, v);
      chk("cold_fill_hit", 32'(h), 32'd0);
      chk("cold_fill_way", 32'(w), 32'(i));
    end
    req_a(OP_LOOKUP, 24'hB0, 3, h, w, v);
    chk("plru_miss_hit", 32'(h), 32'd0);
    chk("plru_miss_victim", 32'(v), 32'd0);
    req_a(OP_LOOKUP, 24'hA0, 3, h, w, v);
    chk("plru_hit_way0", 32'(w), 32'd0);
    req_a(OP_FILL, 24'hB0, 3, h, w, v);
    chk("plru_fill_way", 32'(w), 32'd2);
    req_a(OP_LOOKUP, 24'hA2, 3, h, w, v);
    chk("evicted_miss", 32'(h), 32'd0);

    // Duplicate fill leaves other ways intact.
    req_a(OP_FILL, 24'hA3, 3, h, w, v);
    chk("dup_fill_hit", 32'(h), 32'd1);
    chk("dup_fill_way", 32'(w), 32'd3);
    req_a(OP_LOOKUP, 24'hA0, 3, h, w, v);
    chk("dup_keep_w0", 32'({h, w}), 32'({1'b1, 2'd0}));
    req_a(OP_LOOKUP, 24'hA1, 3, h, w, v);
    chk("dup_keep_w1", 32'({h, w}), 32'({1'b1, 2'd1}));
    req_a(OP_LOOKUP, 24'hB0, 3, h, w, v);
    chk("dup_keep_w2", 32'({h, w}), 32'({1'b1, 2'd2}));

    // Invalidate then refill prefers the invalid way.
    req_a(OP_INVAL, 24'hA1, 3, h, w, v);
    chk("inval_hit", 32'({h, w}), 32'({1'b1, 2'd1}));
    req_a(OP_FILL, 24'hC0, 3, h, w, v);
    chk("refill_invalid_way", 32'(w), 32'd1);
    @(posedge clk); #1;
    chk("idle_no_resp", 32'(bus_a.resp_valid), 32'd0);

    // Flush-all; a request held during the flush must be ignored.
    bus_a.req_valid = 1'b1; bus_a.req_op = OP_FLUSH;
    @(posedge clk); #1;
    bus_a.req_op = OP_FILL; bus_a.req_tag = 24'hEE; bus_a.req_index = 3'd1;
    n = 0; pulses = 0;
    while (!bus_a.req_ready && n < 20) begin
      n++;
      if (bus_a.resp_valid || !bus_a.busy) pulses++;
      @(posedge clk); #1;
    end
    bus_a.req_valid = 1'b0;
    chk("flush_cycles", 32'(n), 32'd8);
    chk("flush_busy_quiet", 32'(pulses), 32'd0);
    chk("flush_done_pulse", 32'(bus_a.resp_valid), 32'd1);
    chk("flush_done_hit", 32'(bus_a.resp_hit), 32'd0);
    chk("flush_done_busy", 32'(bus_a.busy), 32'd0);
    m_clear();
    @(posedge clk); #1;
    chk("flush_single_pulse", 32'(bus_a.resp_valid), 32'd0);
    req_a(OP_LOOKUP, 24'hA0, 3, h, w, v);
    chk("post_flush_A0", 32'(h), 32'd0);
    req_a(OP_LOOKUP, 24'hC0, 3, h, w, v);
    chk("post_flush_C0", 32'(h), 32'd0);

    // Randomized traffic over a small tag pool to force hits, evictions and invalidates.
    for (int k = 0; k < 400; k++) begin
      op_e op;
      op = op_e'(2'($urandom_range(0, 2)));
      req_a(op, 24'hD0 + 24'($urandom_range(0, 11)), int'($urandom_range(0, 7)), h, w, v);
      if ($urandom_range(0, 7) == 0) begin
        @(posedge clk); #1;
        chk("rand_idle_no_resp", 32'(bus_a.resp_valid), 32'd0);
      end
    end

    // Reset in the middle of a flush.
    bus_a.req_valid = 1'b1; bus_a.req_op = OP_FLUSH;
    @(posedge clk); #1;
    bus_a.req_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("midflush_busy", 32'(bus_a.busy), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("midflush_rst_ready", 32'(bus_a.req_ready), 32'd1);
    chk("midflush_rst_busy", 32'(bus_a.busy), 32'd0);
    chk("midflush_rst_valid", 32'(bus_a.resp_valid), 32'd0);
    chk("midflush_rst_way", 32'({bus_a.resp_hit, bus_a.resp_way, bus_a.resp_victim_way}), 32'd0);
    @(negedge clk) reset = 1'b1;
    m_clear();
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (bus_a.resp_valid || !bus_a.req_ready) pulses++;
    end
    chk("midflush_no_pulse", 32'(pulses), 32'd0);
    req_a(OP_LOOKUP, 24'hD3, 2, h, w, v);
    chk("midflush_cleared", 32'(h), 32'd0);

    // Cold fills on the 8-way, 16-set instance.
    for (int i = 0; i < 8; i++) begin
      bus_b.req_valid = 1'b1; bus_b.req_op = OP_FILL;
      bus_b.req_tag = 24'hA0 + 24'(i); bus_b.req_index = 4'd5;
      @(posedge clk); #1;
      chk("b_fill_valid", 32'(bus_b.resp_valid), 32'd1);
      chk("b_fill_hit", 32'(bus_b.resp_hit), 32'd0);
      chk("b_fill_way", 32'(bus_b.resp_way), 32'(i));
    end
    bus_b.req_op = OP_LOOKUP; bus_b.req_tag = 24'hA2;
    @(posedge clk); #1;
    bus_b.req_valid = 1'b0;
    chk("b_lookup_valid", 32'(bus_b.resp_valid), 32'd1);
    chk("b_lookup_hit", 32'(bus_b.resp_hit), 32'd1);
    chk("b_lookup_way", 32'(bus_b.resp_way), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
